// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // Width of a fill counter that must represent both 0 and depth.
  function automatic int unsigned uart_level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for uart_rx_fifo: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  // Left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and uart_debug with a fill-level output.
// Define UART_FIFO_RTS_EN to add the registered rts_n flow-control output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH         = UART_FIFO_DEPTH,
  parameter int unsigned RTS_THRESHOLD = 12,
  localparam int unsigned AW           = $clog2(DEPTH),
  localparam int unsigned LW           = uart_level_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [UART_DATA_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef UART_FIFO_RTS_EN
  output logic                   rts_n,
`endif
  output logic [LW-1:0]          level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

`ifdef UART_FIFO_RTS_EN
  if (RTS_THRESHOLD < 3 || RTS_THRESHOLD > DEPTH) begin : g_bad_rts
    $error("uart_rx_fifo: RTS_THRESHOLD must be within 3..DEPTH");
  end

  logic rts_q, rts_d;

  // Two bytes of hysteresis keep RTS from chattering around the threshold.
  always_comb begin
    rts_d = rts_q;
    if (level_d >= LW'(RTS_THRESHOLD)) begin
      rts_d = 1'b1;
    end else if (level_d < LW'(RTS_THRESHOLD - 2)) begin
      rts_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rts_q <= 1'b0;
    end else begin
      rts_q <= rts_d;
    end
  end

  assign rts_n = rts_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo using a reference queue and level model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned RTS_THR = 12;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
`ifdef UART_FIFO_RTS_EN
  logic          rts_n;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb [$];
  int         model_level = 0;
  logic       model_rts = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH         (DEPTH),
    .RTS_THRESHOLD (RTS_THR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef UART_FIFO_RTS_EN
    .rts_n     (rts_n),
`endif
    .level     (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs against the model, step, check level.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
    logic do_push, do_pop;
    logic [7:0] exp_byte;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(model_level != DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_level != 0));
    do_push = iv && (model_level != DEPTH);
    do_pop  = ordy && (model_level != 0);
    if (do_pop) begin
      exp_byte = sb.pop_front();
      check("out_data", 32'(out_data), 32'(exp_byte));
    end
    if (do_push) sb.push_back(d);
    if (do_push && !do_pop) model_level++;
    if (do_pop && !do_push) model_level--;
    if (model_level >= int'(RTS_THR))        model_rts = 1'b1;
    else if (model_level < int'(RTS_THR) - 2) model_rts = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("level", 32'(level), 32'(model_level));
`ifdef UART_FIFO_RTS_EN
    check("rts_n", 32'(rts_n), 32'(model_rts));
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && model_level > 0; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drained_level", 32'(level), 32'd0);
    check("drained_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
`ifdef UART_FIFO_RTS_EN
    check("rst_rts_n", 32'(rts_n), 32'd0);
`endif
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Three bytes held at the head, then drained in order.
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b1, 8'h43, 1'b0);
    check("head_held", 32'(out_data), 32'h41);
    cycle(1'b0, 8'h00, 1'b0);
    check("head_held2", 32'(out_data), 32'h41);
    drain();

    // Fill, reject overflow, pop one, then accept the rejected byte.
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b1, 8'(i), 1'b0);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < int'(DEPTH) - 1; i++) cycle(1'b0, 8'h00, 1'b1);
    check("last_byte", 32'(out_data), 32'hFF);
    drain();

    // Steady push and pop at level 5; 40 cycles wraps the pointers twice.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1);
    check("steady_level", 32'(level), 32'd5);
    drain();

    // Push into empty with same-cycle out_ready: nothing popped.
    cycle(1'b1, 8'h5A, 1'b1);
    check("empty_push_valid", 32'(out_valid), 32'd1);
    check("empty_push_data", 32'(out_data), 32'h5A);
    check("empty_push_level", 32'(level), 32'd1);
    drain();

    // Asynchronous reset at level 7.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #2;
    resetn = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_level", 32'(level), 32'd0);
    in_valid = 1'b0;
    sb.delete();
    model_level = 0;
    model_rts = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_level", 32'(level), 32'd0);
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b1, 8'hC4, 1'b0);
    check("post_rst_head", 32'(out_data), 32'hC3);
    drain();

`ifdef UART_FIFO_RTS_EN
    for (int i = 0; i < int'(RTS_THR) - 1; i++) cycle(1'b1, 8'(i), 1'b0);
    check("rts_below_thr", 32'(rts_n), 32'd0);
    cycle(1'b1, 8'h77, 1'b0);
    check("rts_at_12", 32'(rts_n), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("rts_at_11", 32'(rts_n), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("rts_at_10", 32'(rts_n), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("rts_at_9", 32'(rts_n), 32'd0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
